// File: rtl/needle_move_scheduler.sv
// Move sequencer for the nand_needle_8bit core: accepts a player or AI move, applies it
// to board memory with a read/clear/write sequence, pulses core_step, then waits to settle.
module needle_move_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned AI_TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       player_valid,
  output logic       player_ready,
  input  logic [5:0] player_from,
  input  logic [5:0] player_to,
  input  logic       ai_auto,
  input  logic       core_ai_valid,
  input  logic [5:0] core_ai_from,
  input  logic [5:0] core_ai_to,
  input  logic       core_slip,
  output logic       core_step,
  output logic [5:0] board_addr,
  output logic       board_we,
  output logic [3:0] board_wdata,
  input  logic [3:0] board_rdata,
  input  logic       slip_ack,
  output logic       slip_hold,
  output logic       side_to_move,
  output logic [7:0] move_count,
  output logic       busy,
  output logic       err_illegal
);

  // state    | meaning
  // IDLE     | waiting for a player move or an AI turn
  // READ     | fetch piece on from-square, reject empty or null moves
  // CLEAR    | write empty to from-square
  // WRITE    | write latched piece to to-square
  // STEP     | one-cycle core_step, toggle side, count move
  // SETTLE   | wait SETTLE_CYCLES, watch core_slip
  // AI_WAIT  | waiting for core_ai_valid on an auto black turn
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CLEAR, S_WRITE, S_STEP, S_SETTLE, S_AI_WAIT
  } state_e;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] AI_LOAD     = 8'(AI_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [5:0] from_q, from_d;
  logic [5:0] to_q, to_d;
  logic [3:0] piece_q, piece_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] ai_cnt_q, ai_cnt_d;
  logic       side_q, side_d;
  logic [7:0] count_q, count_d;
  logic       slip_q, slip_d;
  logic       manual_q, manual_d;
  logic       ready_idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      from_q       <= '0;
      to_q         <= '0;
      piece_q      <= '0;
      settle_cnt_q <= '0;
      ai_cnt_q     <= '0;
      side_q       <= 1'b0;
      count_q      <= '0;
      slip_q       <= 1'b0;
      manual_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      from_q       <= from_d;
      to_q         <= to_d;
      piece_q      <= piece_d;
      settle_cnt_q <= settle_cnt_d;
      ai_cnt_q     <= ai_cnt_d;
      side_q       <= side_d;
      count_q      <= count_d;
      slip_q       <= slip_d;
      manual_q     <= manual_d;
    end
  end

  // manual_q lets the player move black after the AI timed out on this turn
  assign ready_idle = !slip_q && (!(ai_auto && side_q) || manual_q);

  always_comb begin
    state_d      = state_q;
    from_d       = from_q;
    to_d         = to_q;
    piece_d      = piece_q;
    settle_cnt_d = settle_cnt_q;
    ai_cnt_d     = ai_cnt_q;
    side_d       = side_q;
    count_d      = count_q;
    slip_d       = slip_q;
    manual_d     = manual_q;
    player_ready = 1'b0;
    core_step    = 1'b0;
    board_addr   = '0;
    board_we     = 1'b0;
    board_wdata  = '0;
    err_illegal  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        player_ready = ready_idle && !rst;
        if (player_valid && ready_idle) begin
          from_d  = player_from;
          to_d    = player_to;
          state_d = S_READ;
        end else if (ai_auto && side_q && !slip_q && !manual_q) begin
          ai_cnt_d = AI_LOAD;
          state_d  = S_AI_WAIT;
        end
      end
      S_AI_WAIT: begin
        if (core_ai_valid) begin
          from_d  = core_ai_from;
          to_d    = core_ai_to;
          state_d = S_READ;
        end else if (ai_cnt_q == 8'd0) begin
          manual_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          ai_cnt_d = ai_cnt_q - 8'd1;
        end
      end
      S_READ: begin
        board_addr = from_q;
        piece_d    = board_rdata;
        if (board_rdata == 4'd0 || from_q == to_q) begin
          err_illegal = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        board_addr = from_q;
        board_we   = 1'b1;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        board_addr  = to_q;
        board_we    = 1'b1;
        board_wdata = piece_q;
        state_d     = S_STEP;
      end
      S_STEP: begin
        core_step    = 1'b1;
        side_d       = !side_q;
        manual_d     = 1'b0;
        settle_cnt_d = SETTLE_LOAD;
        if (count_q != 8'hFF) count_d = count_q + 8'd1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == 8'd0) state_d = S_IDLE;
        else settle_cnt_d = settle_cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // a slip seen in the same cycle as an ack must not be lost
    if (slip_ack) slip_d = 1'b0;
    if (state_q == S_SETTLE && core_slip) slip_d = 1'b1;
  end

  assign slip_hold    = slip_q;
  assign side_to_move = side_q;
  assign move_count   = count_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_needle_move_scheduler.sv
// Directed bench for needle_move_scheduler with a behavioural board memory.
module tb_needle_move_scheduler;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       player_valid, player_ready;
  logic [5:0] player_from, player_to;
  logic       ai_auto, core_ai_valid;
  logic [5:0] core_ai_from, core_ai_to;
  logic       core_slip, core_step;
  logic [5:0] board_addr;
  logic       board_we;
  logic [3:0] board_wdata, board_rdata;
  logic       slip_ack, slip_hold, side_to_move;
  logic [7:0] move_count;
  logic       busy, err_illegal;

  logic [3:0] board [64];
  logic       load_en;
  logic [5:0] load_addr;
  logic [3:0] load_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign board_rdata = board[board_addr];
  always @(posedge clk) begin
    if (load_en) board[load_addr] <= load_data;
    else if (board_we) board[board_addr] <= board_wdata;
  end

  needle_move_scheduler #(.SETTLE_CYCLES(S), .AI_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .player_valid(player_valid), .player_ready(player_ready),
    .player_from(player_from), .player_to(player_to),
    .ai_auto(ai_auto), .core_ai_valid(core_ai_valid),
    .core_ai_from(core_ai_from), .core_ai_to(core_ai_to),
    .core_slip(core_slip), .core_step(core_step),
    .board_addr(board_addr), .board_we(board_we),
    .board_wdata(board_wdata), .board_rdata(board_rdata),
    .slip_ack(slip_ack), .slip_hold(slip_hold),
    .side_to_move(side_to_move), .move_count(move_count),
    .busy(busy), .err_illegal(err_illegal)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_sq(input logic [5:0] a, input logic [3:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick;
    load_en = 1'b0;
  endtask

  // handshake one player move and wait for the scheduler to return to IDLE
  task automatic apply_move(input logic [5:0] f, input logic [5:0] t);
    int n;
    player_from = f; player_to = t; player_valid = 1'b1;
    n = 0;
    while (player_ready !== 1'b1 && n < 600) begin tick; n++; end
    n_cmp++; if (player_ready !== 1'b1) begin n_err++; $display("FAIL apply_ready_timeout got %b exp 1", player_ready); end
    tick;
    player_valid = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 600) begin tick; n++; end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL apply_busy_timeout got %b exp 0", busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    player_valid = 0; player_from = 0; player_to = 0; ai_auto = 0;
    core_ai_valid = 0; core_ai_from = 0; core_ai_to = 0; core_slip = 0; slip_ack = 0;
    load_en = 0; load_addr = 0; load_data = 0;
    #3;
    n_cmp++; if ({player_ready, busy, core_step, board_we, err_illegal, slip_hold, side_to_move} !== 7'b0) begin
      n_err++; $display("FAIL reset_flags got %b exp 0000000", {player_ready, busy, core_step, board_we, err_illegal, slip_hold, side_to_move}); end
    n_cmp++; if ({board_addr, board_wdata, move_count} !== 18'd0) begin
      n_err++; $display("FAIL reset_buses got addr=%0d wdata=%0d count=%0d exp 0", board_addr, board_wdata, move_count); end
    for (int i = 0; i < 64; i++) begin
      if (i >= 8 && i < 16) load_sq(6'(i), 4'd1);
      else if (i >= 48 && i < 56) load_sq(6'(i), 4'd9);
      else load_sq(6'(i), 4'd0);
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (player_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle got ready=%b busy=%b exp ready=1 busy=0", player_ready, busy); end
  endtask

  task automatic test_player_move;
    player_from = 6'd12; player_to = 6'd28; player_valid = 1'b1;
    n_cmp++; if (player_ready !== 1'b1) begin n_err++; $display("FAIL e4_ready got %b exp 1", player_ready); end
    tick; player_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || board_addr !== 6'd12 || board_we !== 1'b0) begin
      n_err++; $display("FAIL e4_read got busy=%b addr=%0d we=%b exp 1 12 0", busy, board_addr, board_we); end
    tick;
    n_cmp++; if (board_we !== 1'b1 || board_addr !== 6'd12 || board_wdata !== 4'd0) begin
      n_err++; $display("FAIL e4_clear got we=%b addr=%0d wdata=%0d exp 1 12 0", board_we, board_addr, board_wdata); end
    tick;
    n_cmp++; if (board_we !== 1'b1 || board_addr !== 6'd28 || board_wdata !== 4'd1) begin
      n_err++; $display("FAIL e4_write got we=%b addr=%0d wdata=%0d exp 1 28 1", board_we, board_addr, board_wdata); end
    tick;
    n_cmp++; if (core_step !== 1'b1 || board_we !== 1'b0) begin
      n_err++; $display("FAIL e4_step got step=%b we=%b exp 1 0", core_step, board_we); end
    tick;
    n_cmp++; if (core_step !== 1'b0 || side_to_move !== 1'b1 || move_count !== 8'd1 || busy !== 1'b1) begin
      n_err++; $display("FAIL e4_settle got step=%b side=%b count=%0d busy=%b exp 0 1 1 1", core_step, side_to_move, move_count, busy); end
    for (int i = 0; i < S - 1; i++) tick;
    n_cmp++; if (busy !== 1'b1 || player_ready !== 1'b0) begin
      n_err++; $display("FAIL e4_last_settle got busy=%b ready=%b exp 1 0", busy, player_ready); end
    tick;
    n_cmp++; if (busy !== 1'b0 || player_ready !== 1'b1) begin
      n_err++; $display("FAIL e4_idle got busy=%b ready=%b exp 0 1", busy, player_ready); end
    n_cmp++; if (board[12] !== 4'd0 || board[28] !== 4'd1) begin
      n_err++; $display("FAIL e4_board got sq12=%0d sq28=%0d exp 0 1", board[12], board[28]); end
  endtask

  task automatic test_illegal;
    logic [5:0] fr [2];
    logic [5:0] tt [2];
    fr[0] = 6'd20; tt[0] = 6'd28;
    fr[1] = 6'd28; tt[1] = 6'd28;
    for (int k = 0; k < 2; k++) begin
      player_from = fr[k]; player_to = tt[k]; player_valid = 1'b1;
      tick; player_valid = 1'b0;
      n_cmp++; if (err_illegal !== 1'b1 || board_we !== 1'b0 || core_step !== 1'b0) begin
        n_err++; $display("FAIL illegal%0d_read got err=%b we=%b step=%b exp 1 0 0", k, err_illegal, board_we, core_step); end
      tick;
      n_cmp++; if (busy !== 1'b0 || err_illegal !== 1'b0 || board_we !== 1'b0) begin
        n_err++; $display("FAIL illegal%0d_idle got busy=%b err=%b we=%b exp 0 0 0", k, busy, err_illegal, board_we); end
      n_cmp++; if (side_to_move !== 1'b1 || move_count !== 8'd1) begin
        n_err++; $display("FAIL illegal%0d_state got side=%b count=%0d exp 1 1", k, side_to_move, move_count); end
    end
  endtask

  task automatic test_ai_move;
    ai_auto = 1'b1;
    #1;
    n_cmp++; if (player_ready !== 1'b0) begin n_err++; $display("FAIL ai_ready got %b exp 0", player_ready); end
    tick;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ai_wait_busy got %b exp 1", busy); end
    tick; tick;
    core_ai_from = 6'd52; core_ai_to = 6'd36; core_ai_valid = 1'b1;
    tick; core_ai_valid = 1'b0;
    n_cmp++; if (board_addr !== 6'd52 || board_we !== 1'b0 || err_illegal !== 1'b0) begin
      n_err++; $display("FAIL ai_read got addr=%0d we=%b err=%b exp 52 0 0", board_addr, board_we, err_illegal); end
    tick;
    n_cmp++; if (board_we !== 1'b1 || board_addr !== 6'd52 || board_wdata !== 4'd0) begin
      n_err++; $display("FAIL ai_clear got we=%b addr=%0d wdata=%0d exp 1 52 0", board_we, board_addr, board_wdata); end
    tick;
    n_cmp++; if (board_we !== 1'b1 || board_addr !== 6'd36 || board_wdata !== 4'd9) begin
      n_err++; $display("FAIL ai_write got we=%b addr=%0d wdata=%0d exp 1 36 9", board_we, board_addr, board_wdata); end
    tick;
    n_cmp++; if (core_step !== 1'b1) begin n_err++; $display("FAIL ai_step got %b exp 1", core_step); end
    tick;
    n_cmp++; if (side_to_move !== 1'b0 || move_count !== 8'd2) begin
      n_err++; $display("FAIL ai_after got side=%b count=%0d exp 0 2", side_to_move, move_count); end
    for (int i = 0; i < S; i++) tick;
    n_cmp++; if (busy !== 1'b0 || player_ready !== 1'b1) begin
      n_err++; $display("FAIL ai_idle got busy=%b ready=%b exp 0 1", busy, player_ready); end
  endtask

  task automatic test_ai_timeout;
    apply_move(6'd11, 6'd27);
    n_cmp++; if (player_ready !== 1'b0 || side_to_move !== 1'b1 || move_count !== 8'd3) begin
      n_err++; $display("FAIL to_start got ready=%b side=%b count=%0d exp 0 1 3", player_ready, side_to_move, move_count); end
    for (int i = 0; i < 255; i++) tick;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL to_last_wait got busy=%b exp 1", busy); end
    tick;
    n_cmp++; if (busy !== 1'b0 || player_ready !== 1'b1 || side_to_move !== 1'b1) begin
      n_err++; $display("FAIL to_fallback got busy=%b ready=%b side=%b exp 0 1 1", busy, player_ready, side_to_move); end
    apply_move(6'd51, 6'd35);
    n_cmp++; if (move_count !== 8'd4 || side_to_move !== 1'b0 || board[35] !== 4'd9 || board[51] !== 4'd0) begin
      n_err++; $display("FAIL to_manual_move got count=%0d side=%b sq35=%0d sq51=%0d exp 4 0 9 0", move_count, side_to_move, board[35], board[51]); end
    ai_auto = 1'b0;
  endtask

  task automatic test_slip;
    player_from = 6'd8; player_to = 6'd16; player_valid = 1'b1;
    tick; player_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    core_slip = 1'b1; slip_ack = 1'b1;
    tick; core_slip = 1'b0; slip_ack = 1'b0;
    n_cmp++; if (slip_hold !== 1'b1) begin n_err++; $display("FAIL slip_set_wins got %b exp 1", slip_hold); end
    tick; tick;
    n_cmp++; if (busy !== 1'b0 || slip_hold !== 1'b1 || player_ready !== 1'b0) begin
      n_err++; $display("FAIL slip_idle got busy=%b hold=%b ready=%b exp 0 1 0", busy, slip_hold, player_ready); end
    player_from = 6'd9; player_to = 6'd17; player_valid = 1'b1;
    tick; player_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0 || move_count !== 8'd5) begin
      n_err++; $display("FAIL slip_block got busy=%b count=%0d exp 0 5", busy, move_count); end
    slip_ack = 1'b1;
    tick; slip_ack = 1'b0;
    n_cmp++; if (slip_hold !== 1'b0 || player_ready !== 1'b1 || side_to_move !== 1'b1) begin
      n_err++; $display("FAIL slip_ack got hold=%b ready=%b side=%b exp 0 1 1", slip_hold, player_ready, side_to_move); end
  endtask

  task automatic test_reset_mid;
    player_from = 6'd49; player_to = 6'd41; player_valid = 1'b1;
    tick; player_valid = 1'b0;
    tick; tick;
    n_cmp++; if (board_we !== 1'b1 || board_addr !== 6'd41) begin
      n_err++; $display("FAIL rmid_write got we=%b addr=%0d exp 1 41", board_we, board_addr); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({player_ready, busy, core_step, board_we, err_illegal, slip_hold, side_to_move} !== 7'b0 ||
                 board_addr !== 6'd0 || board_wdata !== 4'd0 || move_count !== 8'd0) begin
      n_err++; $display("FAIL rmid_zero got flags=%b addr=%0d wdata=%0d count=%0d exp 0", {player_ready, busy, core_step, board_we, err_illegal, slip_hold, side_to_move}, board_addr, board_wdata, move_count); end
    tick;
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || player_ready !== 1'b1 || board[49] !== 4'd0 || board[41] !== 4'd0) begin
      n_err++; $display("FAIL rmid_after got busy=%b ready=%b sq49=%0d sq41=%0d exp 0 1 0 0", busy, player_ready, board[49], board[41]); end
  endtask

  task automatic test_saturation;
    load_sq(6'd0, 4'd3);
    load_sq(6'd1, 4'd0);
    for (int i = 0; i < 255; i++) begin
      if (i % 2 == 0) apply_move(6'd0, 6'd1);
      else apply_move(6'd1, 6'd0);
    end
    n_cmp++; if (move_count !== 8'd255 || side_to_move !== 1'b1 || board[1] !== 4'd3) begin
      n_err++; $display("FAIL sat_255 got count=%0d side=%b sq1=%0d exp 255 1 3", move_count, side_to_move, board[1]); end
    apply_move(6'd1, 6'd0);
    n_cmp++; if (move_count !== 8'd255 || side_to_move !== 1'b0 || board[0] !== 4'd3) begin
      n_err++; $display("FAIL sat_hold got count=%0d side=%b sq0=%0d exp 255 0 3", move_count, side_to_move, board[0]); end
  endtask

  initial begin
    test_reset;
    test_player_move;
    test_illegal;
    test_ai_move;
    test_ai_timeout;
    test_slip;
    test_reset_mid;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/needle_move_scheduler.md
# needle_move_scheduler

Sequencer in front of the `nand_needle_8bit` core. It accepts a move from the player, or from the core's own AI suggestion, and applies it to the board memory with a read/clear/write sequence. It then pulses the core's `step` input and waits a settle window before granting the next move. It replaces hand-driven board pokes and `step` pulses in benches and on the board top level. It also tracks side-to-move, counts moves, and holds off new moves after a friction slip until software acknowledges it.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4: cycles waited after `core_step` before the next move is accepted (1..255).
- `AI_TIMEOUT`, 255: cycles to wait for `core_ai_valid` in auto mode (1..255).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `player_valid`  in  1  player move request.
- `player_ready`  out  1  scheduler can accept a player move this cycle.
- `player_from`  in  6  source square (0 = a1, 63 = h8).
- `player_to`  in  6  destination square.
- `ai_auto`  in  1  when 1, black moves are taken from the core AI.
- `core_ai_valid`  in  1  core AI suggestion valid.
- `core_ai_from`  in  6  AI source square.
- `core_ai_to`  in  6  AI destination square.
- `core_slip`  in  1  core slip flag.
- `core_step`  out  1  one-cycle step pulse to the core.
- `board_addr`  out  6  board memory square address.
- `board_we`  out  1  board write enable.
- `board_wdata`  out  4  piece code to write.
- `board_rdata`  in  4  piece at `board_addr`, combinational (same-cycle) read.
- `slip_ack`  in  1  clears `slip_hold`.
- `slip_hold`  out  1  a slip was seen; moves are blocked.
- `side_to_move`  out  1  0 = white, 1 = black.
- `move_count`  out  8  applied half-moves, saturates at 255.
- `busy`  out  1  state is not IDLE.
- `err_illegal`  out  1  one-cycle pulse: move rejected.

## Operation
- States: IDLE, READ, CLEAR, WRITE, STEP, SETTLE, AI_WAIT.
- Reset values:
  - state = IDLE.
  - All outputs = 0, so `side_to_move` = white.
  - Latched from/to/piece = 0; counters = 0.
- IDLE:
  - `player_ready` = 1 when none of these hold: `slip_hold`; or `ai_auto` and `side_to_move` = 1.
  - Handshake: `player_valid && player_ready` latches from/to and goes to READ.
  - If `ai_auto` and `side_to_move` = 1 and not `slip_hold`, go to AI_WAIT.
- AI_WAIT:
  - `core_ai_valid` latches `core_ai_from`/`core_ai_to` and goes to READ.
  - After `AI_TIMEOUT` cycles without valid, return to IDLE with `player_ready` forced 1 for this black turn (manual fallback).
- READ:
  - `board_addr` = from; `board_rdata` is latched as the piece.
  - If the piece is 0, or from == to: pulse `err_illegal`, go to IDLE. Side and count are unchanged.
- CLEAR: `board_addr` = from, `board_we` = 1, `board_wdata` = 0.
- WRITE: `board_addr` = to, `board_we` = 1, `board_wdata` = latched piece. A capture simply overwrites the destination.
- STEP:
  - `core_step` = 1 for exactly one cycle.
  - `side_to_move` toggles.
  - `move_count` increments, saturating at 255.
- SETTLE:
  - Count `SETTLE_CYCLES` cycles.
  - `core_slip` = 1 on any cycle of the window sets `slip_hold`.
  - Then go to IDLE.
- `slip_hold`:
  - Set only in SETTLE; cleared by `slip_ack` in any state.
  - Set wins over `slip_ack` in the same cycle.
- `board_we` is 0 in every state except CLEAR and WRITE.
- `board_addr` is 0 in states that do not drive it.

## Timing
- Player handshake accepted at cycle T:
  - READ at T+1, CLEAR at T+2, WRITE at T+3.
  - `core_step` high at T+4.
  - SETTLE from T+5 to T+4+SETTLE_CYCLES.
  - IDLE (`player_ready` may rise) at T+5+SETTLE_CYCLES.
- AI path: `core_ai_valid` sampled at cycle A gives READ at A+1, with the same downstream timing.
- Rejected move: `err_illegal` pulses in the READ cycle (T+1); IDLE at T+2.
- `player_valid` while `player_ready` = 0 is ignored and not queued; the requester holds it.
- `busy` = 1 from T+1 until the cycle before IDLE is re-entered.
- Reset mid-sequence returns to IDLE immediately. A partially applied move (from-square cleared, to-square not yet written) is left as is; software must reload the board.

## Test plan
- Reset, then load the start position. Player e2→e4 (12→28): writes are addr 12 ← 0 at T+2 and addr 28 ← 0001 at T+3; `core_step` at T+4; `side_to_move` = 1; `move_count` = 1; `player_ready` at T+5+SETTLE_CYCLES.
- Player move from an empty square (from = 20) → `err_illegal` pulse at T+1; no `board_we`, no `core_step`; side and count unchanged. Same result for from == to (12→12).
- `ai_auto` = 1 after white e4; core presents 52→36 three cycles later → READ the next cycle, writes 52 ← 0 and 36 ← 1001, `core_step`, `side_to_move` back to 0, `move_count` = 2.
- `ai_auto` = 1 and `core_ai_valid` never asserted → after 255 cycles state = IDLE and `player_ready` = 1 with `side_to_move` = 1; a player black move is then applied.
- `core_slip` pulsed in the 2nd settle cycle → `slip_hold` = 1, `player_ready` stays 0. `slip_ack` clears it next cycle and `player_ready` returns to 1.
- Assert `rst` during WRITE → all outputs 0 the same cycle, state IDLE, `move_count` 0. Also saturation: after 255 applied moves, the next move leaves `move_count` = 255.
